// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta DAC front end: default widths and
// the sample-feeder FSM state encoding.
package sd_pkg;

    localparam int SD_DW    = 4;
    localparam int SD_OSR   = 16;
    localparam int SD_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sd_state_e;

    // Occupancy after one edge given a write and a pop decision.
    function automatic int unsigned sd_fill_next(input int unsigned fill,
                                                 input logic wr,
                                                 input logic rd);
        return fill + (wr ? 1 : 0) - (rd ? 1 : 0);
    endfunction

endpackage

// File: rtl/sd_sync_fifo.sv
// Single-clock FIFO with registered occupancy and a combinational head read;
// pointers wrap naturally because DEPTH is a power of two.
module sd_sync_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FW-1:0] fill_q, fill_d;
    logic          wr_ok, rd_ok;

    // Guard against protocol misuse so occupancy can never overflow or wrap.
    assign wr_ok  = wr_en && !full;
    assign rd_ok  = rd_en && !empty;
    assign fill_d = fill_q + FW'(wr_ok) - FW'(rd_ok);

    assign full    = (fill_q == FW'(DEPTH));
    assign empty   = (fill_q == '0);
    assign fill    = fill_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            fill_q <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/sd_sample_feeder.sv
// Buffers PCM samples and holds each on x1 for OSR clocks (zero-order hold),
// with a per-sample strobe and a sticky underrun flag.
module sd_sample_feeder
    import sd_pkg::*;
#(
    parameter int DW    = SD_DW,
    parameter int OSR   = SD_OSR,
    parameter int DEPTH = SD_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW-1:0]           s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DW-1:0]           x1,
    output logic                    x1_strobe,
    output logic                    underrun,
    input  logic                    clr_underrun,
    output logic [$clog2(DEPTH):0]  fill
);

    localparam int PW = $clog2(OSR);
    localparam int FW = $clog2(DEPTH) + 1;

    sd_state_e     state_q;
    logic [PW-1:0] phase_q;
    logic [DW-1:0] x1_q;
    logic          x1_strobe_q;
    logic          underrun_q;
    logic          s_ready_q;

    logic          wr, pop, boundary, last_phase;
    logic          fifo_full, fifo_empty;
    logic [DW-1:0] head;
    logic [FW-1:0] fill_d;

    sd_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (head),
        .fill    (fill),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Pops look only at registered occupancy, so a same-edge write is never
    // eligible for the pop on that edge.
    always_comb begin
        last_phase = (phase_q == PW'(OSR - 1));
        boundary   = (state_q == IDLE) || last_phase;
        wr         = s_valid && s_ready_q && !fifo_full;
        pop        = boundary && !fifo_empty;
        fill_d     = FW'(sd_fill_next(int'(fill), wr, pop));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            x1_q        <= '0;
            x1_strobe_q <= 1'b0;
            underrun_q  <= 1'b0;
            s_ready_q   <= 1'b0;
        end else begin
            s_ready_q   <= (fill_d != FW'(DEPTH));
            x1_strobe_q <= pop;
            if (pop) x1_q <= head;

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= RUN;
                        phase_q <= '0;
                    end
                end
                RUN: begin
                    // An empty boundary keeps the hold running rather than
                    // dropping back to IDLE, so the output cadence is kept.
                    phase_q <= last_phase ? '0 : phase_q + PW'(1);
                end
                default: state_q <= IDLE;
            endcase

            if ((state_q == RUN) && last_phase && fifo_empty)
                underrun_q <= 1'b1;
            else if (clr_underrun)
                underrun_q <= 1'b0;
        end
    end

    assign s_ready   = s_ready_q;
    assign x1        = x1_q;
    assign x1_strobe = x1_strobe_q;
    assign underrun  = underrun_q;

    a_strobe_in_run: assert property (@(posedge clk) disable iff (!rst)
        x1_strobe_q |-> (state_q == RUN));
    a_no_write_full: assert property (@(posedge clk) disable iff (!rst)
        s_ready_q |-> !fifo_full);

endmodule
